// File: rtl/cpu_hazard_pkg.sv
// Shared definitions for the hazard-detection and forwarding logic:
// FSM state encoding, zero-register index, default memory timeout and
// the load-use hazard predicate.
package cpu_hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } hazard_state_e;

    // X31 is the zero register: writes to it are discarded, so it never
    // creates a real data dependency.
    localparam logic [4:0] XZR = 5'd31;

    localparam int MEM_TIMEOUT_DEFAULT = 15;

    // True when the load in EX produces a register the ID instruction reads.
    function automatic logic load_use_hazard(
        input logic [4:0] aa_id,
        input logic [4:0] ab_id,
        input logic       use_a_id,
        input logic       use_b_id,
        input logic [4:0] aw_ex,
        input logic       mem_read_ex,
        input logic       reg_write_ex
    );
        logic match_a;
        logic match_b;
        match_a = use_a_id && (aa_id == aw_ex);
        match_b = use_b_id && (ab_id == aw_ex);
        return mem_read_ex && reg_write_ex && (aw_ex != XZR) && (match_a || match_b);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Stops at all-ones instead of wrapping.
module sat_counter #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [width-1:0] count
);

    logic [width-1:0] count_q;
    logic [width-1:0] count_d;

    // Next value: increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {width{1'b1}})) begin
            count_d = count_q + width'(1);
        end
    end

    // Count register, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall controller: load-use bubbles, taken-branch
// flushes and whole-pipeline freezes while data memory is busy, with a
// sticky timeout if memory never answers. Controls are combinational
// from state and inputs; three saturating counters track each event.
//
// Handshake: the memory access is a req/ready pair. memReqMEM=1 with
// memReadyMEM=0 means "not done yet" and freezes the pipe; the cycle
// where memReadyMEM=1 completes the access and the pipe moves that
// same cycle.
module hazard_stall_unit
    import cpu_hazard_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       AaID,
    input  logic [4:0]       AbID,
    input  logic             useAID,
    input  logic             useBID,
    input  logic [4:0]       AwEX,
    input  logic             memReadEX,
    input  logic             regWriteEX,
    input  logic             branchTakenEX,
    input  logic             memReqMEM,
    input  logic             memReadyMEM,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             idexBubble,
    output logic             ifidFlush,
    output logic             idexFlush,
    output logic             pipeFreeze,
    output logic             memTimeout,
    output logic [CNT_W-1:0] loadStallCnt,
    output logic [CNT_W-1:0] flushCnt,
    output logic [CNT_W-1:0] memWaitCnt,
    output hazard_state_e    state_o
);

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    hazard_state_e     state_q;
    hazard_state_e     state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic [WAIT_W-1:0] wait_inc;

    logic hazard;
    logic freeze;
    logic evaluate;

    assign hazard = load_use_hazard(AaID, AbID, useAID, useBID,
                                    AwEX, memReadEX, regWriteEX);
    assign wait_inc = wait_q + WAIT_W'(1);

    // Next-state and control outputs. A freeze suppresses branch and
    // hazard handling; the held EX instruction is judged again once the
    // freeze lifts. Reset forces the idle control pattern.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        freeze     = 1'b0;
        evaluate   = 1'b0;
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        idexBubble = 1'b0;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        pipeFreeze = 1'b0;
        memTimeout = 1'b0;

        if (!reset) begin
            unique case (state_q)
                RUN: begin
                    if (memReqMEM && !memReadyMEM) begin
                        freeze  = 1'b1;
                        state_d = MEM_WAIT;
                        wait_d  = '0;
                    end else begin
                        evaluate = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!memReadyMEM) begin
                        freeze = 1'b1;
                        if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
                            state_d = TIMEOUT;
                        end else begin
                            wait_d = wait_inc;
                        end
                    end else begin
                        evaluate = 1'b1;
                        state_d  = RUN;
                    end
                end
                TIMEOUT: begin
                    freeze     = 1'b1;
                    memTimeout = 1'b1;
                end
                default: begin
                    state_d = RUN;
                end
            endcase

            if (freeze) begin
                pipeFreeze = 1'b1;
                pcWrite    = 1'b0;
                ifidWrite  = 1'b0;
            end else if (evaluate) begin
                if (branchTakenEX) begin
                    // Flush outranks the bubble: the dependent instruction
                    // is on the wrong path anyway.
                    ifidFlush = 1'b1;
                    idexFlush = 1'b1;
                end else if (hazard) begin
                    pcWrite    = 1'b0;
                    ifidWrite  = 1'b0;
                    idexBubble = 1'b1;
                end
            end
        end
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign state_o = state_q;

    sat_counter #(.width(CNT_W)) u_load_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (idexBubble),
        .count (loadStallCnt)
    );

    sat_counter #(.width(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ifidFlush),
        .count (flushCnt)
    );

    sat_counter #(.width(CNT_W)) u_mem_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (pipeFreeze),
        .count (memWaitCnt)
    );

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of each performance counter.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, giving the maximum number of consecutive memory-wait cycles before an error.
REQ-003 SHALL have ports, listed as name, direction, width, meaning:
- clk  in  1  single clock for the block.
- reset  in  1  reset, asynchronous and active-high.
- AaID  in  5  register-file read address A of the instruction in ID.
- AbID  in  5  register-file read address B of the instruction in ID.
- useAID  in  1  ID instruction reads A.
- useBID  in  1  ID instruction reads B.
- AwEX  in  5  destination register of the instruction in EX.
- memReadEX  in  1  EX instruction is a load.
- regWriteEX  in  1  EX instruction writes the register file.
- branchTakenEX  in  1  branch resolved taken in EX.
- memReqMEM  in  1  MEM stage has an active data-memory access.
- memReadyMEM  in  1  data memory completes the access this cycle.
- pcWrite  out  1  PC may update.
- ifidWrite  out  1  IF/ID register may load.
- idexBubble  out  1  zero the ID/EX control fields (NOP).
- ifidFlush  out  1  squash IF/ID.
- idexFlush  out  1  squash ID/EX.
- pipeFreeze  out  1  hold every pipeline register.
- memTimeout  out  1  sticky error flag.
- loadStallCnt  out  CNT_W  count of load-use bubble cycles.
- flushCnt  out  CNT_W  count of flush cycles.
- memWaitCnt  out  CNT_W  count of freeze cycles.

Function
REQ-004 SHALL implement an FSM with states RUN, MEM_WAIT and TIMEOUT.
REQ-005 SHALL define a load-use hazard as all of the following: memReadEX=1, regWriteEX=1, AwEX!=31, and ((useAID=1 and AaID==AwEX) or (useBID=1 and AbID==AwEX)).
REQ-006 SHALL, in RUN with memReqMEM=1 and memReadyMEM=0, drive pipeFreeze=1, pcWrite=0 and ifidWrite=0 that cycle, with all other controls 0, and go to MEM_WAIT next.
REQ-007 SHALL, in RUN with no memory wait and branchTakenEX=1, drive ifidFlush=1, idexFlush=1, pcWrite=1 and ifidWrite=1 that cycle; the branch flush outranks a load-use hazard.
REQ-008 SHALL, in RUN with no memory wait, no branch and a load-use hazard, drive pcWrite=0, ifidWrite=0 and idexBubble=1 for exactly that cycle.
REQ-009 SHALL, in RUN with no condition active, drive pcWrite=1 and ifidWrite=1, with all other controls 0.
REQ-010 SHALL, in MEM_WAIT with memReadyMEM=0, hold the REQ-006 outputs and increment an internal wait counter.
REQ-011 SHALL, in MEM_WAIT with memReadyMEM=1, drop pipeFreeze in that same cycle, evaluate REQ-007 to REQ-009 in that cycle, and go to RUN.
REQ-012 SHALL enter TIMEOUT when the wait counter reaches MEM_TIMEOUT with memReadyMEM still 0.
REQ-013 SHALL, in TIMEOUT, hold memTimeout=1 and the REQ-006 outputs until reset, ignoring all inputs.
REQ-014 SHALL ignore branchTakenEX and load-use hazards in every cycle where pipeFreeze=1; the frozen EX instruction is re-evaluated when the freeze drops.
REQ-015 SHALL clear the wait counter on every entry to MEM_WAIT.
REQ-016 SHALL produce all control outputs combinationally from the current state and inputs, with zero-cycle latency.
REQ-017 SHALL increment loadStallCnt in each cycle with idexBubble=1.
REQ-018 SHALL increment flushCnt in each cycle with ifidFlush=1.
REQ-019 SHALL increment memWaitCnt in each cycle with pipeFreeze=1.
REQ-020 SHALL saturate each counter at 2^CNT_W-1, with no wrap-around.
REQ-021 SHALL never assert idexBubble and idexFlush together, and never assert pipeFreeze together with any flush or bubble output.

Reset
REQ-022 SHALL, while reset=1 and independent of clk, force: state RUN, wait counter 0, all counters 0, memTimeout=0, pcWrite=1, ifidWrite=1, all other outputs 0.
REQ-023 SHALL, on reset asserted in MEM_WAIT or TIMEOUT, abandon the wait and resume RUN evaluation on the first clk edge after reset deasserts.

Structure
REQ-024 SHALL take the FSM state enum, the constant XZR=5'd31 and the default MEM_TIMEOUT from shared package cpu_hazard_pkg, shared with the forwarding logic.
REQ-025 SHALL build each performance counter from one instance of a sub-module named sat_counter (parameter width; ports clk, reset, inc, count).

Verification
REQ-026 SHALL cover: LDUR X3 in EX, ADD reading X3 on A in ID -> exactly one cycle of pcWrite=0, ifidWrite=0, idexBubble=1; loadStallCnt=1.
REQ-027 SHALL cover: load with AwEX=31 and AaID=31 -> no bubble; pcWrite=1.
REQ-028 SHALL cover: branchTakenEX=1 together with a load-use hazard -> ifidFlush=1, idexFlush=1, idexBubble=0; flushCnt=1.
REQ-029 SHALL cover: memReqMEM=1 with memReadyMEM low for 3 cycles and then high -> pipeFreeze=1 for 3 cycles and 0 in the ready cycle; memWaitCnt=3; state back to RUN.
REQ-030 SHALL cover: memReadyMEM held low for 16 cycles -> memTimeout=1 and pipeFreeze=1 persist; reset clears both asynchronously.
REQ-031 SHALL cover: CNT_W=4 with 20 consecutive hazards -> loadStallCnt saturates at 15.
